// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle shared by the image loader and its driver.
// The master side feeds bytes and Start; the slave side is the loader.
interface imem_loader_if;
    logic        Start;
    logic [7:0]  RX_Data;
    logic        RX_Valid;
    logic        RX_Ready;
    logic        IM_WE;
    logic [31:0] IM_Addr;
    logic [31:0] IM_WD;
    logic        Loading;
    logic        Done;
    logic        Error;

    modport master (
        output Start, RX_Data, RX_Valid,
        input  RX_Ready, IM_WE, IM_Addr, IM_WD, Loading, Done, Error
    );

    modport slave (
        input  Start, RX_Data, RX_Valid,
        output RX_Ready, IM_WE, IM_Addr, IM_WD, Loading, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// Parses a framed byte image (16-bit word count, little-endian words, XOR checksum)
// and writes the words into instruction memory while holding the processor in reset.
module imem_loader #(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input logic         CLK,
    input logic         RESETn,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  acc;
    logic [23:0] word_buf;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic        rx_ready;
    logic        xfer;
    logic        last_word;
    logic [16:0] len_full;

    assign rx_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CHECK);
    // Start wins over a byte offered in the same cycle; that byte is dropped.
    assign xfer      = bus.RX_Valid && rx_ready && !bus.Start;
    assign last_word = (byte_cnt == 2'd3) && (word_idx == count - 16'd1);
    assign len_full  = {1'b0, bus.RX_Data, count[7:0]};

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.Start) begin
            state_next = LEN_LO;
        end else if (xfer) begin
            case (state)
                LEN_LO: state_next = LEN_HI;
                LEN_HI: begin
                    if (len_full > DEPTH_W) begin
                        state_next = ERROR;
                    end else if (len_full == 17'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (last_word) begin
                        state_next = CHECK;
                    end
                end
                CHECK: state_next = (bus.RX_Data == acc) ? DONE : ERROR;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            acc      <= '0;
            word_buf <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (bus.Start) begin
                count    <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                acc      <= '0;
            end else if (xfer) begin
                acc <= acc ^ bus.RX_Data;
                case (state)
                    LEN_LO: count[7:0]  <= bus.RX_Data;
                    LEN_HI: count[15:8] <= bus.RX_Data;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.RX_Data;
                            2'd1: word_buf[15:8]  <= bus.RX_Data;
                            2'd2: word_buf[23:16] <= bus.RX_Data;
                            default: begin
                                wd_q     <= {bus.RX_Data, word_buf};
                                addr_q   <= ADDR_BASE + {14'd0, word_idx, 2'b00};
                                we_q     <= 1'b1;
                                word_idx <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.RX_Ready = rx_ready;
    assign bus.Loading  = rx_ready;
    assign bus.Done     = (state == DONE);
    assign bus.Error    = (state == ERROR);
    assign bus.IM_WE    = we_q;
    assign bus.IM_Addr  = addr_q;
    assign bus.IM_WD    = wd_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader; expected writes and outcome come from
// a frame-level model that decodes the byte image directly.
module tb_imem_loader;

    localparam int          DEPTH     = 128;
    localparam logic [31:0] ADDR_BASE = 32'h0;

    typedef logic [7:0] byte_q_t[$];

    logic CLK = 1'b0;
    logic RESETn = 1'b0;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_BASE(ADDR_BASE)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic [63:0] got_writes[$];
    logic [63:0] exp_writes[$];
    logic        exp_done;
    logic        exp_error;

    // Every cycle with IM_WE high is one memory write.
    always @(negedge CLK) begin
        if (bus.IM_WE === 1'b1) got_writes.push_back({bus.IM_Addr, bus.IM_WD});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xorAll(input byte_q_t b);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    function automatic void modelImage(input byte_q_t b);
        int cnt;
        logic [7:0] x;
        exp_writes.delete();
        cnt = int'(b[1]) * 256 + int'(b[0]);
        if (cnt > DEPTH) begin
            exp_done  = 1'b0;
            exp_error = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * cnt; i++) x ^= b[i];
        for (int w = 0; w < cnt; w++) begin
            exp_writes.push_back({ADDR_BASE + 32'(4 * w),
                                  b[5 + 4 * w], b[4 + 4 * w], b[3 + 4 * w], b[2 + 4 * w]});
        end
        exp_done  = (b[2 + 4 * cnt] == x);
        exp_error = !exp_done;
    endfunction

    task automatic applyStimulus(input byte_q_t b, input bit gapped);
        foreach (b[i]) begin
            if (gapped) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.RX_Valid = 1'b0;
                    bus.RX_Data  = 8'($urandom);
                    @(posedge CLK); #1;
                end
            end
            bus.RX_Data  = b[i];
            bus.RX_Valid = 1'b1;
            @(posedge CLK); #1;
        end
        bus.RX_Valid = 1'b0;
    endtask

    task automatic pulseStart();
        bus.Start = 1'b1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        checkOutput("start_ready", 32'(bus.RX_Ready), 32'd1);
        checkOutput("start_loading", 32'(bus.Loading), 32'd1);
        checkOutput("start_done_clear", 32'(bus.Done), 32'd0);
        checkOutput("start_error_clear", 32'(bus.Error), 32'd0);
    endtask

    task automatic runImage(input string tag, input byte_q_t b, input bit gapped, input bit do_start);
        int n;
        if (do_start) pulseStart();
        got_writes.delete();
        modelImage(b);
        applyStimulus(b, gapped);
        checkOutput({tag, "_done"}, 32'(bus.Done), 32'(exp_done));
        checkOutput({tag, "_error"}, 32'(bus.Error), 32'(exp_error));
        checkOutput({tag, "_loading"}, 32'(bus.Loading), 32'd0);
        checkOutput({tag, "_ready"}, 32'(bus.RX_Ready), 32'd0);
        @(posedge CLK); #1;
        checkOutput({tag, "_nwrites"}, 32'(got_writes.size()), 32'(exp_writes.size()));
        n = (got_writes.size() < exp_writes.size()) ? got_writes.size() : exp_writes.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_addr"}, got_writes[i][63:32], exp_writes[i][63:32]);
            checkOutput({tag, "_data"}, got_writes[i][31:0], exp_writes[i][31:0]);
        end
        got_writes.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.RX_Ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(bus.IM_WE), 32'd0);
        checkOutput({tag, "_addr"}, bus.IM_Addr, 32'd0);
        checkOutput({tag, "_wd"}, bus.IM_WD, 32'd0);
        checkOutput({tag, "_loading"}, 32'(bus.Loading), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.Done), 32'd0);
        checkOutput({tag, "_error"}, 32'(bus.Error), 32'd0);
    endtask

    initial begin
        byte_q_t two_word;
        byte_q_t bad;
        byte_q_t s;
        logic [31:0] w;
        int cnt;

        bus.Start    = 1'b0;
        bus.RX_Valid = 1'b0;
        bus.RX_Data  = 8'h00;
        two_word = '{8'h02, 8'h00, 8'h04, 8'h12, 8'h9F, 8'hE5,
                     8'h04, 8'h92, 8'h9F, 8'hE5, 8'h82};

        #2;
        checkResetValues("reset");
        #20 RESETn = 1'b1;
        @(posedge CLK); #1;
        bus.RX_Valid = 1'b1;
        @(posedge CLK); #1;
        checkOutput("idle_ready", 32'(bus.RX_Ready), 32'd0);
        checkOutput("idle_loading", 32'(bus.Loading), 32'd0);
        bus.RX_Valid = 1'b0;

        $display("[TB] two-word load");
        runImage("two_word", two_word, 1'b0, 1'b1);

        $display("[TB] bad checksum");
        bad = two_word;
        bad[10] = 8'h83;
        runImage("bad_sum", bad, 1'b0, 1'b1);

        $display("[TB] oversize count");
        pulseStart();
        got_writes.delete();
        applyStimulus('{8'h81, 8'h00}, 1'b0);
        checkOutput("over_error", 32'(bus.Error), 32'd1);
        checkOutput("over_done", 32'(bus.Done), 32'd0);
        checkOutput("over_ready", 32'(bus.RX_Ready), 32'd0);
        checkOutput("over_loading", 32'(bus.Loading), 32'd0);
        applyStimulus('{8'h04, 8'h12, 8'h9F, 8'hE5, 8'h00}, 1'b0);
        checkOutput("over_nwrites", 32'(got_writes.size()), 32'd0);
        checkOutput("over_error_held", 32'(bus.Error), 32'd1);

        $display("[TB] full-depth image");
        s.delete();
        s.push_back(8'h80);
        s.push_back(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) s.push_back(w[8 * k +: 8]);
        end
        s.push_back(xorAll(s));
        runImage("full_depth", s, 1'b0, 1'b1);

        $display("[TB] zero count");
        runImage("zero", '{8'h00, 8'h00, 8'h00}, 1'b0, 1'b1);

        $display("[TB] gapped stream");
        runImage("gapped", two_word, 1'b1, 1'b1);

        $display("[TB] abort and restart");
        pulseStart();
        applyStimulus('{8'h02, 8'h00, 8'h04, 8'h12}, 1'b0);
        bus.Start    = 1'b1;
        bus.RX_Valid = 1'b1;
        bus.RX_Data  = 8'h55;
        @(posedge CLK); #1;
        bus.Start    = 1'b0;
        bus.RX_Valid = 1'b0;
        runImage("restart", two_word, 1'b0, 1'b0);

        $display("[TB] mid-load reset");
        pulseStart();
        applyStimulus('{8'h02, 8'h00, 8'h04, 8'h12, 8'h9F, 8'hE5}, 1'b0);
        checkOutput("pre_reset_we", 32'(bus.IM_WE), 32'd1);
        checkOutput("pre_reset_addr", bus.IM_Addr, ADDR_BASE);
        checkOutput("pre_reset_wd", bus.IM_WD, 32'hE59F1204);
        RESETn = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(posedge CLK); #3;
        RESETn = 1'b1;
        @(posedge CLK); #1;
        runImage("after_reset", two_word, 1'b0, 1'b1);

        $display("[TB] randomized images");
        for (int t = 0; t < 10; t++) begin
            cnt = $urandom_range(0, 6);
            s.delete();
            s.push_back(8'(cnt));
            s.push_back(8'h00);
            for (int i = 0; i < 4 * cnt; i++) s.push_back(8'($urandom));
            s.push_back(xorAll(s));
            if ($urandom_range(0, 2) == 0) s[s.size() - 1] ^= 8'($urandom_range(1, 255));
            runImage("random", s, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
